shift_add_mac: RTL and testbench
================================

// Module: shift_add_mac
// PURPOSE
//  Sequential multiply-accumulate stage sitting directly downstream of the operand registers
//  (one_bit_register banks). Accepts an operand pair a, b via valid/ready and multiplies
//  them unsigned by iterative shift-and-add over WIDTH cycles.
//  Adds the product into a running accumulator and exposes the accumulator, a one-cycle
//  out_valid strobe and a sticky overflow flag to the downstream consumer.
// PARAMETERS
//  WIDTH      8   operand width in bits (a, b); also the number of multiply iterations
//  ACC_WIDTH  20  accumulator width in bits; must be >= 2*WIDTH
// PORTS
//  clk        in   1          single clock, all state updates on rising edge
//  reset      in   1          asynchronous, active-low; 0 forces reset state immediately
//  in_valid   in   1          operand pair a/b is valid
//  in_ready   out  1          block can accept an operand pair (state IDLE)
//  a          in   WIDTH      multiplicand, unsigned
//  b          in   WIDTH      multiplier, unsigned
//  clear      in   1          zero accumulator and overflow; honoured only in IDLE
//  acc        out  ACC_WIDTH  accumulator value, unsigned
//  out_valid  out  1          one-cycle strobe: acc has just been updated
//  overflow   out  1          sticky: accumulator has wrapped since last clear/reset
//  busy       out  1          high in MULT and ACC (== ~in_ready)
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE, acc=0, overflow=0, out_valid=0, in_ready=1, busy=0.
//    All internal shift/partial registers are zeroed. An in-flight operation is discarded.
//  FSM: IDLE -> MULT -> ACC -> IDLE.
//  IDLE:
//    - Accept edge (in_valid & in_ready): latch a into mcand (2*WIDTH, zero-extended),
//      latch b into mplier, zero product, zero the step counter, go to MULT.
//    - in_ready=1 and busy=0 throughout IDLE.
//  MULT: each edge, if mplier[0] then product += mcand; then mcand <<= 1, mplier >>= 1.
//    - counter increments each edge; after exactly WIDTH edges go to ACC.
//    - No early exit on mplier==0.
//  ACC: one edge. {carry, acc} = acc + zero_ext(product).
//    - Result wraps modulo 2^ACC_WIDTH; overflow |= carry.
//    - out_valid=1 for exactly the next cycle; state returns to IDLE.
//  Latency: out_valid high WIDTH+1 cycles after the accept edge; acc is stable while out_valid=1.
//  Throughput: one op per WIDTH+2 cycles. in_ready=1 in the out_valid cycle, so the next
//    accept can occur on that edge.
//  Handshake: a/b are sampled only on the accept edge. in_valid held while busy is not
//    consumed and stays pending until in_ready=1.
//  clear:
//    - In IDLE: acc=0 and overflow=0 at the next edge.
//    - Same edge as an accept: clear takes effect, the operation starts, and its product
//      later adds into 0.
//    - While busy: ignored, not queued.
//  Max product (2^WIDTH-1)^2 fits in 2*WIDTH bits; the product register never overflows.
//  Reset mid-operation: outputs reach reset values without waiting for clk.
// STRUCTURE
//  Shared header mac_defs.vh holds:
//    - FSM state encodings IDLE/MULT/ACC (2-bit)
//    - default WIDTH/ACC_WIDTH constants
//    - the counter-width expression $clog2(WIDTH+1)
//  One natural sub-module, shift_add_multiplier:
//    - contains the mcand/mplier/product registers and the step counter
//    - interface: start, done, product
//  shift_add_mac owns the FSM, the handshake, the accumulator and the overflow flag.
// TESTING (WIDTH=8, ACC_WIDTH=20)
//  1. reset=0 then 1; a=3, b=5, in_valid for one cycle -> in_ready=0 for 9 cycles;
//     out_valid pulses 1 cycle; acc=15, overflow=0.
//  2. Continuing from 1: a=255, b=255 -> acc=65040. Then a=0, b=200 -> acc unchanged
//     (65040) with out_valid still pulsed.
//  3. clear=1 in IDLE -> acc=0 next cycle. clear pulsed while busy -> acc not cleared;
//     result adds to the previous value.
//  4. After clear, 17 ops of 255*255 -> after the 16th op acc=1040400, overflow=0;
//     after the 17th acc=56849, overflow=1; a further 1*1 keeps overflow=1.
//  5. in_valid held high continuously with changing a/b -> one accept per 10 cycles;
//     each result uses the a/b present on its accept edge.
//  6. Drive reset=0 mid-MULT, asynchronous to clk -> acc=0, out_valid=0, in_ready=1
//     immediately; no out_valid pulse after release.

Source files
------------

// File: rtl/shift_add_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mac_pkg
// Brief    : Shared constants for the shift-and-add multiply-accumulate block:
//            FSM state encodings, default widths and counter-width helper.
// Revision : 1.0  initial release
// ============================================================================
package shift_add_mac_pkg;

    // Default operand and accumulator widths
    localparam int unsigned C_DEF_WIDTH     = 8;
    localparam int unsigned C_DEF_ACC_WIDTH = 20;

    // FSM state encodings
    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_MULT = 2'd1;
    localparam logic [1:0] C_ST_ACC  = 2'd2;

    // Step counter must be able to hold the value WIDTH
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_add_mac_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_multiplier
// Brief    : Iterative unsigned shift-and-add multiplier. start loads the
//            operands; each step cycle adds the shifted multiplicand when the
//            current multiplier bit is set. done flags the final step.
// Revision : 1.0  initial release
// ============================================================================
module shift_add_multiplier
    import shift_add_mac_pkg::*;
#(
    parameter int unsigned WIDTH = C_DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned C_CNT_W = cnt_width(WIDTH);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_product;
    logic [C_CNT_W-1:0] r_count;

    // Load operands on start, otherwise perform one shift-and-add step per step cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_product <= '0;
            r_count   <= '0;
        end else if (start) begin
            r_mcand   <= (2*WIDTH)'(a);
            r_mplier  <= b;
            r_product <= '0;
            r_count   <= '0;
        end else if (step) begin
            if (r_mplier[0]) begin
                r_product <= r_product + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
        end
    end

    // The step taken while the counter sits at WIDTH-1 is the last one
    assign done    = step && (r_count == C_LAST);
    assign product = r_product;

endmodule
`default_nettype wire

// File: rtl/shift_add_mac.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mac
// Brief    : Sequential multiply-accumulate stage. Accepts an operand pair via
//            valid/ready, multiplies over WIDTH cycles, adds the product into a
//            wrapping accumulator and raises a sticky overflow flag on carry.
// Revision : 1.0  initial release
// ============================================================================
module shift_add_mac
    import shift_add_mac_pkg::*;
#(
    parameter int unsigned WIDTH     = C_DEF_WIDTH,
    parameter int unsigned ACC_WIDTH = C_DEF_ACC_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 clear,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 out_valid,
    output logic                 overflow,
    output logic                 busy
);

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic                 w_start;
    logic                 w_step;
    logic                 w_done;
    logic [2*WIDTH-1:0]   w_product;
    logic [ACC_WIDTH:0]   w_sum;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_overflow;
    logic                 r_out_valid;

    assign w_start = in_valid && in_ready;
    assign w_step  = (r_state == C_ST_MULT);

    shift_add_multiplier #(
        .WIDTH   (WIDTH)
    ) u_mult (
        .clk     (clk),
        .reset   (reset),
        .start   (w_start),
        .step    (w_step),
        .a       (a),
        .b       (b),
        .done    (w_done),
        .product (w_product)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> MULT on accept, MULT -> ACC after the last step, ACC -> IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_ST_IDLE: if (in_valid) w_next_state = C_ST_MULT;
            C_ST_MULT: if (w_done)   w_next_state = C_ST_ACC;
            C_ST_ACC:                w_next_state = C_ST_IDLE;
            default:                 w_next_state = C_ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        in_ready = (r_state == C_ST_IDLE);
        busy     = (r_state != C_ST_IDLE);
    end

    // Extra top bit of the sum captures the carry out of the accumulator
    assign w_sum = {1'b0, r_acc} + (ACC_WIDTH+1)'(w_product);

    // Accumulator, sticky overflow and result strobe; clear only acts while idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc       <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (r_state == C_ST_ACC);
            if (r_state == C_ST_ACC) begin
                r_acc      <= w_sum[ACC_WIDTH-1:0];
                r_overflow <= r_overflow | w_sum[ACC_WIDTH];
            end else if ((r_state == C_ST_IDLE) && clear) begin
                r_acc      <= '0;
                r_overflow <= 1'b0;
            end
        end
    end

    assign acc       = r_acc;
    assign overflow  = r_overflow;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_mac
// Brief    : Self-checking bench for shift_add_mac (WIDTH=8, ACC_WIDTH=20)
//            with a cycle-count reference model and directed plus random
//            stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_shift_add_mac;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned ACC_WIDTH = 20;
    localparam longint      C_MOD     = 64'd1 << ACC_WIDTH;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 clear;
    logic [ACC_WIDTH-1:0] acc;
    logic                 out_valid;
    logic                 overflow;
    logic                 busy;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    shift_add_mac #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .clear     (clear),
        .acc       (acc),
        .out_valid (out_valid),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an operation occupies WIDTH+1 edges after its accept,
    // then the product a*b is added modulo 2^ACC_WIDTH.
    longint m_acc;
    bit     m_ovf;
    bit     m_outv;
    int     m_left;
    longint m_prod;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_acc = 0; m_ovf = 0; m_outv = 0; m_left = 0; m_prod = 0;
        end else begin
            m_outv = 0;
            if (m_left == 0) begin
                if (clear) begin m_acc = 0; m_ovf = 0; end
                if (in_valid) begin
                    m_prod = longint'(a) * longint'(b);
                    m_left = WIDTH + 1;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    longint s;
                    s = m_acc + m_prod;
                    if (s >= C_MOD) m_ovf = 1;
                    m_acc  = s % C_MOD;
                    m_outv = 1;
                end
            end
        end
    end

    // Compare DUT outputs against the model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("acc",       longint'(acc),       m_acc);
            chk("overflow",  longint'(overflow),  longint'(m_ovf));
            chk("out_valid", longint'(out_valid), longint'(m_outv));
            chk("in_ready",  longint'(in_ready),  longint'(m_left == 0));
            chk("busy",      longint'(busy),      longint'(m_left != 0));
        end
    end

    // One operation: present a/b for one cycle, optionally clear on accept or
    // while busy, and wait (bounded) for the result strobe.
    int busy_n;
    task automatic op(input int av, input int bv, input bit clr_acc, input bit clr_busy);
        in_valid = 1'b1; a = WIDTH'(av); b = WIDTH'(bv); clear = clr_acc;
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b0;
        busy_n = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) break;
            if (!in_ready) busy_n++;
            if (clr_busy && i == 2) clear = 1'b1;
            if (clr_busy && i == 3) clear = 1'b0;
            @(negedge clk);
        end
        clear = 1'b0;
        if (!out_valid) chk("op_timeout", 0, 1);
    endtask

    int pulses;

    initial begin
        reset = 1'b0; in_valid = 1'b0; a = '0; b = '0; clear = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_acc", longint'(acc), 0);
        chk("rst_ready", longint'(in_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Basic product and latency
        op(3, 5, 0, 0);
        chk("t1_acc", longint'(acc), 15);
        chk("t1_busy_cycles", busy_n, 9);
        chk("t1_ovf", longint'(overflow), 0);

        // Max operands, then zero multiplicand
        op(255, 255, 0, 0);
        chk("t2_acc", longint'(acc), 65040);
        op(0, 200, 0, 0);
        chk("t2_zero_acc", longint'(acc), 65040);

        // Clear in idle, then clear while busy is ignored
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("t3_clear", longint'(acc), 0);
        op(3, 5, 0, 0);
        op(2, 2, 0, 1);
        chk("t3_busy_clear", longint'(acc), 19);

        // Clear on the accept edge: product adds into zero
        op(4, 4, 1, 0);
        chk("t3_clear_accept", longint'(acc), 16);

        // Accumulator wrap and sticky overflow
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int k = 0; k < 16; k++) op(255, 255, 0, 0);
        chk("t4_acc16", longint'(acc), 1040400);
        chk("t4_ovf16", longint'(overflow), 0);
        op(255, 255, 0, 0);
        chk("t4_acc17", longint'(acc), 56849);
        chk("t4_ovf17", longint'(overflow), 1);
        op(1, 1, 0, 0);
        chk("t4_ovf_sticky", longint'(overflow), 1);

        // Continuous in_valid with changing operands: one accept per 10 cycles
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        pulses = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            @(negedge clk);
            if (out_valid) pulses++;
        end
        in_valid = 1'b0;
        chk("t5_pulses", pulses, 5);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            clear    = ($urandom_range(0, 7) == 0);
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0; clear = 1'b0;
        repeat (12) @(negedge clk);

        // Asynchronous reset in the middle of a multiply
        in_valid = 1'b1; a = 8'd7; b = 8'd9;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("t6_acc", longint'(acc), 0);
        chk("t6_outv", longint'(out_valid), 0);
        chk("t6_ready", longint'(in_ready), 1);
        chk("t6_busy", longint'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("t6_no_pulse", pulses, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
